unified_memory_arbiter: RTL and testbench

Shares one single-port, word-addressed unified memory between the instruction-fetch requester and the load/store requester of the core. Each cycle at most one request is granted. The granted request drives the memory port combinationally. Its response is registered and returned one cycle later. Data accesses have priority; a starvation counter guarantees forward progress for fetch. The block also flags misaligned and out-of-range addresses.

---
 rtl/unified_memory_arbiter_if.sv | 48 ++++
 rtl/unified_memory_arbiter.sv | 126 ++++++++++++
 tb/tb_unified_memory_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/unified_memory_arbiter_if.sv
// Request/response and memory-port bundle between the core requesters, the
// unified memory arbiter and the single-port memory.
interface unified_memory_arbiter_if #(
   parameter int DEPTH = 256
);
   localparam int AW = $clog2(DEPTH);

   logic          if_req_valid;
   logic [31:0]   if_req_addr;
   logic          if_req_ready;
   logic          if_rsp_valid;
   logic [31:0]   if_rsp_data;
   logic          if_rsp_err;

   logic          d_req_valid;
   logic          d_req_we;
   logic [31:0]   d_req_addr;
   logic [31:0]   d_req_wdata;
   logic [3:0]    d_req_wmask;
   logic          d_req_ready;
   logic          d_rsp_valid;
   logic [31:0]   d_rsp_data;
   logic          d_rsp_err;

   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_rdata;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wmask;

   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wmask,
      output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
      output mem_addr, mem_we, mem_wdata, mem_wmask,
      input  mem_rdata
   );

   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wmask,
      input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
      input  mem_addr, mem_we, mem_wdata, mem_wmask,
      output mem_rdata
   );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Single-port unified memory arbiter: data-priority grant with a fetch
// starvation guard, one-cycle registered responses and address fault flags.
module unified_memory_arbiter #(
   parameter int DEPTH        = 256,
   parameter int STARVE_LIMIT = 4
) (
   input logic                    clk,
   input logic                    reset,
   unified_memory_arbiter_if.slave bus
);
   localparam int         AW    = $clog2(DEPTH);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} rsp_state_t;

   function automatic logic f_fault(input logic [31:0] addr);
      f_fault = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
   endfunction

   logic          w_if_fault, w_d_fault, w_if_gnt, w_d_gnt;
   logic [AW-1:0] w_mem_addr;
   logic [31:0]   w_mem_wdata;
   logic [3:0]    w_mem_wmask;
   logic          w_mem_we;
   logic [3:0]    w_starve_nxt;
   rsp_state_t    w_if_state_nxt, w_d_state_nxt;
   logic [31:0]   w_if_data_nxt, w_d_data_nxt;
   logic          w_if_err_nxt, w_d_err_nxt;

   logic [3:0]    r_starve;
   rsp_state_t    r_if_state, r_d_state;
   logic [31:0]   r_if_data, r_d_data;
   logic          r_if_err, r_d_err;

   // Grant selection and memory port drive; reset blocks every grant.
   always_comb begin
      w_if_fault  = f_fault(bus.if_req_addr);
      w_d_fault   = f_fault(bus.d_req_addr);
      w_if_gnt    = 1'b0;
      w_d_gnt     = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = 32'h0000_0000;
      w_mem_wmask = 4'b0000;
      w_mem_we    = 1'b0;
      if (reset) begin
         w_if_gnt = 1'b0;
         w_d_gnt  = 1'b0;
      end else begin
         w_if_gnt = bus.if_req_valid && (!bus.d_req_valid || (r_starve == LIMIT));
         w_d_gnt  = bus.d_req_valid && !w_if_gnt;
      end
      if (w_if_gnt) begin
         w_mem_addr = bus.if_req_addr[2 +: AW];
      end else if (w_d_gnt) begin
         w_mem_addr  = bus.d_req_addr[2 +: AW];
         w_mem_wdata = bus.d_req_wdata;
         w_mem_wmask = bus.d_req_wmask;
         w_mem_we    = bus.d_req_we && !w_d_fault;
      end else begin
         w_mem_addr = '0;
      end
   end

   // Starvation counter and response next-state/data.
   always_comb begin
      w_starve_nxt = r_starve;
      if (!bus.if_req_valid || w_if_gnt) begin
         w_starve_nxt = 4'd0;
      end else if (r_starve < LIMIT) begin
         w_starve_nxt = r_starve + 4'd1;
      end else begin
         w_starve_nxt = r_starve;
      end

      w_if_state_nxt = S_IDLE;
      case (r_if_state)
         S_IDLE, S_RESP: w_if_state_nxt = w_if_gnt ? S_RESP : S_IDLE;
         default:        w_if_state_nxt = S_IDLE;
      endcase
      w_d_state_nxt = S_IDLE;
      case (r_d_state)
         S_IDLE, S_RESP: w_d_state_nxt = w_d_gnt ? S_RESP : S_IDLE;
         default:        w_d_state_nxt = S_IDLE;
      endcase

      // Faulted or store responses carry zero data.
      w_if_data_nxt = (w_if_gnt && !w_if_fault) ? bus.mem_rdata : 32'h0000_0000;
      w_if_err_nxt  = w_if_gnt && w_if_fault;
      w_d_data_nxt  = (w_d_gnt && !bus.d_req_we && !w_d_fault) ? bus.mem_rdata : 32'h0000_0000;
      w_d_err_nxt   = w_d_gnt && w_d_fault;
   end

   // State, counter and response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve   <= 4'd0;
         r_if_state <= S_IDLE;
         r_d_state  <= S_IDLE;
         r_if_data  <= 32'h0000_0000;
         r_d_data   <= 32'h0000_0000;
         r_if_err   <= 1'b0;
         r_d_err    <= 1'b0;
      end else begin
         r_starve   <= w_starve_nxt;
         r_if_state <= w_if_state_nxt;
         r_d_state  <= w_d_state_nxt;
         r_if_data  <= w_if_data_nxt;
         r_d_data   <= w_d_data_nxt;
         r_if_err   <= w_if_err_nxt;
         r_d_err    <= w_d_err_nxt;
      end
   end

   assign bus.if_req_ready = w_if_gnt;
   assign bus.d_req_ready  = w_d_gnt;
   assign bus.mem_addr     = w_mem_addr;
   assign bus.mem_wdata    = w_mem_wdata;
   assign bus.mem_wmask    = w_mem_wmask;
   assign bus.mem_we       = w_mem_we;
   assign bus.if_rsp_valid = (r_if_state == S_RESP);
   assign bus.if_rsp_data  = r_if_data;
   assign bus.if_rsp_err   = r_if_err;
   assign bus.d_rsp_valid  = (r_d_state == S_RESP);
   assign bus.d_rsp_data   = r_d_data;
   assign bus.d_rsp_err    = r_d_err;
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed and randomized-valid bench for unified_memory_arbiter with a
// behavioural single-port memory attached to the memory port.
module tb_unified_memory_arbiter;
   localparam int DEPTH = 256;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mem [0:DEPTH-1];

   unified_memory_arbiter_if #(.DEPTH(DEPTH)) bus ();

   unified_memory_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] mask);
      f_merge = old_w;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) f_merge[8*b +: 8] = new_w[8*b +: 8];
      end
   endfunction

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= f_merge(mem[bus.mem_addr], bus.mem_wdata, bus.mem_wmask);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.if_req_valid = 1'b0;
      bus.if_req_addr  = 32'h0;
      bus.d_req_valid  = 1'b0;
      bus.d_req_we     = 1'b0;
      bus.d_req_addr   = 32'h0;
      bus.d_req_wdata  = 32'h0;
      bus.d_req_wmask  = 4'b0000;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dreq(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask);
      bus.d_req_valid = 1'b1;
      bus.d_req_we    = we;
      bus.d_req_addr  = addr;
      bus.d_req_wdata = wdata;
      bus.d_req_wmask = mask;
   endtask

   initial begin
      logic [31:0] fetch_exp [0:2];
      logic        iv, dv, exp_if, exp_d;
      logic [31:0] ia, da, exp_idata, exp_ddata;
      int          cnt;

      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 | 32'(i);
      mem[0] = 32'h0000_0011;
      mem[1] = 32'h0000_0022;
      mem[2] = 32'h0000_0033;
      mem[4] = 32'h1234_5678;
      mem[5] = 32'hCAFE_F00D;
      fetch_exp[0] = 32'h11; fetch_exp[1] = 32'h22; fetch_exp[2] = 32'h33;

      // Reset state with a store pending
      idle();
      reset = 1'b1;
      dreq(1'b1, 32'h14, 32'hFFFF_FFFF, 4'b1111);
      #3;
      chk("rst_d_ready", bus.d_req_ready, 1'b0);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_if_rsp_valid", bus.if_rsp_valid, 1'b0);
      chk("rst_d_rsp_valid", bus.d_rsp_valid, 1'b0);
      chk("rst_d_rsp_data", bus.d_rsp_data, 32'h0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'h0);
      tick();
      tick();
      chk("rst_mem_unchanged", mem[5], 32'hCAFE_F00D);
      idle();
      reset = 1'b0;

      // Back-to-back fetches
      for (int i = 0; i < 3; i++) begin
         bus.if_req_valid = 1'b1;
         bus.if_req_addr  = 32'(4 * i);
         #1;
         chk("fetch_ready", bus.if_req_ready, 1'b1);
         tick();
         chk("fetch_rsp_valid", bus.if_rsp_valid, 1'b1);
         chk("fetch_rsp_data", bus.if_rsp_data, fetch_exp[i]);
         chk("fetch_rsp_err", bus.if_rsp_err, 1'b0);
      end
      idle();
      tick();
      chk("fetch_rsp_drop", bus.if_rsp_valid, 1'b0);

      // Masked store then load of the same word
      dreq(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
      #1;
      chk("st_ready", bus.d_req_ready, 1'b1);
      chk("st_mem_we", bus.mem_we, 1'b1);
      chk("st_mem_addr", 32'(bus.mem_addr), 32'h4);
      tick();
      chk("st_rsp_valid", bus.d_rsp_valid, 1'b1);
      chk("st_rsp_data", bus.d_rsp_data, 32'h0);
      chk("st_mem_word", mem[4], 32'h1234_BEEF);
      dreq(1'b0, 32'h10, 32'h0, 4'b0000);
      tick();
      chk("ld_rsp_valid", bus.d_rsp_valid, 1'b1);
      chk("ld_rsp_data", bus.d_rsp_data, 32'h1234_BEEF);
      chk("ld_rsp_err", bus.d_rsp_err, 1'b0);
      idle();
      tick();

      // Contention: fetch wins every fifth cycle
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h4;
      dreq(1'b0, 32'h14, 32'h0, 4'b0000);
      for (int c = 1; c <= 10; c++) begin
         #1;
         chk("cont_if_ready", bus.if_req_ready, (c == 5) || (c == 10));
         chk("cont_d_ready", bus.d_req_ready, !((c == 5) || (c == 10)));
         tick();
         if ((c == 5) || (c == 10)) chk("cont_if_data", bus.if_rsp_data, 32'h22);
         else chk("cont_d_data", bus.d_rsp_data, 32'hCAFE_F00D);
      end
      idle();
      tick();

      // Address faults
      dreq(1'b0, 32'h3, 32'h0, 4'b0000);
      tick();
      chk("flt_ld_valid", bus.d_rsp_valid, 1'b1);
      chk("flt_ld_err", bus.d_rsp_err, 1'b1);
      chk("flt_ld_data", bus.d_rsp_data, 32'h0);
      dreq(1'b1, 32'(4 * DEPTH), 32'h5555_5555, 4'b1111);
      #1;
      chk("flt_st_ready", bus.d_req_ready, 1'b1);
      chk("flt_st_mem_we", bus.mem_we, 1'b0);
      tick();
      chk("flt_st_err", bus.d_rsp_err, 1'b1);
      chk("flt_st_mem0", mem[0], 32'h11);
      idle();
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h2;
      tick();
      chk("flt_if_valid", bus.if_rsp_valid, 1'b1);
      chk("flt_if_err", bus.if_rsp_err, 1'b1);
      chk("flt_if_data", bus.if_rsp_data, 32'h0);
      idle();
      tick();

      // Reset asserted mid-access
      dreq(1'b0, 32'h0, 32'h0, 4'b0000);
      tick();
      chk("mid_pre_rsp", bus.d_rsp_valid, 1'b1);
      dreq(1'b1, 32'h14, 32'h0, 4'b1111);
      #1;
      chk("mid_we_before", bus.mem_we, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_mem_we", bus.mem_we, 1'b0);
      chk("mid_d_ready", bus.d_req_ready, 1'b0);
      chk("mid_d_rsp_valid", bus.d_rsp_valid, 1'b0);
      chk("mid_if_rsp_valid", bus.if_rsp_valid, 1'b0);
      tick();
      chk("mid_mem_unchanged", mem[5], 32'hCAFE_F00D);
      chk("mid_no_rsp", bus.d_rsp_valid, 1'b0);
      idle();
      reset = 1'b0;
      tick();

      // Randomized valids, loads only, against an independent grant model
      cnt = 0;
      for (int n = 0; n < 1000; n++) begin
         iv = 1'($urandom_range(0, 1));
         dv = 1'($urandom_range(0, 1));
         ia = 32'($urandom_range(0, 15)) << 2;
         da = 32'($urandom_range(0, 15)) << 2;
         bus.if_req_valid = iv;
         bus.if_req_addr  = ia;
         bus.d_req_valid  = dv;
         bus.d_req_we     = 1'b0;
         bus.d_req_addr   = da;
         #1;
         exp_if    = iv && (!dv || (cnt == LIMIT));
         exp_d     = dv && !exp_if;
         exp_idata = mem[ia[9:2]];
         exp_ddata = mem[da[9:2]];
         chk("rnd_both_ready", bus.if_req_ready & bus.d_req_ready, 1'b0);
         chk("rnd_ready_wo_valid", (bus.if_req_ready & !iv) | (bus.d_req_ready & !dv), 1'b0);
         chk("rnd_if_ready", bus.if_req_ready, exp_if);
         chk("rnd_d_ready", bus.d_req_ready, exp_d);
         if (!iv || exp_if) cnt = 0;
         else if (cnt < LIMIT) cnt++;
         tick();
         chk("rnd_if_rsp_valid", bus.if_rsp_valid, exp_if);
         chk("rnd_d_rsp_valid", bus.d_rsp_valid, exp_d);
         if (exp_if) chk("rnd_if_data", bus.if_rsp_data, exp_idata);
         if (exp_d) chk("rnd_d_data", bus.d_rsp_data, exp_ddata);
      end
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
